// File: rtl/spm_stream.sv
// spm_stream: serial-parallel carry-save multiplier with valid/ready handshakes.
// Operand a is held in parallel; b is streamed LSB-first through WIDTH
// carry-save cells, and the product is collected LSB-first in p_sr.
// Optional macro SPM_SIGNED_EN selects two's-complement operands.
module spm_stream #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(PW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PW - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef SPM_SIGNED_EN
    // Carry of the negative-weight cell starts at 1, pre-biasing the
    // accumulator so the subtracting cell never needs a per-cycle constant.
    localparam logic [WIDTH-1:0] C_INIT = MSB_MASK;
`else
    localparam logic [WIDTH-1:0] C_INIT = '0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic [PW-1:0]    p_sr;
    logic [CNT_W-1:0] cnt;

    logic             y;
    logic             b_fill;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] c_nxt;
    logic [PW-1:0]    p_sr_nxt;
    logic [WIDTH-1:0] b_sr_nxt;

    // Carry-save cell chain: partial products, full adders, product and multiplier shifts.
    always_comb begin
        y = b_sr[0];
`ifdef SPM_SIGNED_EN
        // MSB cell subtracts its partial product; b sign-extends past WIDTH bits.
        pp     = (a_q & {WIDTH{y}}) ^ MSB_MASK;
        b_fill = b_sr[WIDTH-1];
`else
        // Zero fill makes y=0 once all WIDTH multiplier bits have been used.
        pp     = a_q & {WIDTH{y}};
        b_fill = 1'b0;
`endif
        s_in     = {1'b0, s_q[WIDTH-1:1]};
        s_nxt    = pp ^ s_in ^ c_q;
        c_nxt    = (pp & s_in) | (pp & c_q) | (s_in & c_q);
        p_sr_nxt = {s_nxt[0], p_sr[PW-1:1]};
        b_sr_nxt = {b_fill, b_sr[WIDTH-1:1]};
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_sr      <= '0;
            s_q       <= '0;
            c_q       <= '0;
            p_sr      <= '0;
            cnt       <= '0;
            p         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_sr     <= b;
                        s_q      <= '0;
                        c_q      <= C_INIT;
                        p_sr     <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    s_q  <= s_nxt;
                    c_q  <= c_nxt;
                    p_sr <= p_sr_nxt;
                    b_sr <= b_sr_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        p         <= p_sr_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_stream.sv
// tb_spm_stream: directed bench for spm_stream at WIDTH=8 and WIDTH=32.
// Expected products follow SPM_SIGNED_EN when the macro is defined.
module tb_spm_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] p32;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SPM_SIGNED_EN
    localparam logic [15:0] EXP_FF = 16'h0001;
    localparam logic [63:0] EXP_32 = 64'hFFFF_FFFF_FFFF_FFFE;
`else
    localparam logic [15:0] EXP_FF = 16'hFE01;
    localparam logic [63:0] EXP_32 = 64'h0000_0001_FFFF_FFFE;
`endif

    spm_stream #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .p(p8), .busy(busy8)
    );

    spm_stream #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .p(p32), .busy(busy32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation with stray in_valid pulses in RUN and DONE.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [15:0] exp, input int hold);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready8), 64'd1);
        a8 = ta; b8 = tb; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        in_valid8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
        chk({tag, "_busy"}, 64'(busy8), 64'd1);
        chk({tag, "_in_ready_run"}, 64'(in_ready8), 64'd0);
        while (!out_valid8 && n < 100) begin
            in_valid8 = (n == 3);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd16);
        chk({tag, "_p"}, 64'(p8), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            in_valid8 = 1'b1;
            @(negedge clk);
            chk({tag, "_hold_p"}, 64'(p8), 64'(exp));
            chk({tag, "_hold_valid"}, 64'(out_valid8), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(in_ready8), 64'd0);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        in_valid8  = 1'b0;
        chk({tag, "_post_valid"}, 64'(out_valid8), 64'd0);
        chk({tag, "_post_in_ready"}, 64'(in_ready8), 64'd1);
        chk({tag, "_post_p"}, 64'(p8), 64'(exp));
    endtask

    initial begin
        int n;
        int acc_cnt;
        int acc_cyc[3];
        int out_cnt;

        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready8), 64'd1);
        chk("rst_out_valid", 64'(out_valid8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_p", 64'(p8), 64'd0);
        chk("rst_p32", p32, 64'd0);

        op8("ff_ff", 8'hFF, 8'hFF, EXP_FF, 0);
        op8("zero_a", 8'h00, 8'hA5, 16'h0000, 0);
        op8("zero_b", 8'h3C, 8'h00, 16'h0000, 0);
        op8("hold", 8'd13, 8'd11, 16'h008F, 10);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready8), 64'd1);
        chk("midrst_out_valid", 64'(out_valid8), 64'd0);
        chk("midrst_busy", 64'(busy8), 64'd0);
        chk("midrst_p", 64'(p8), 64'd0);
        op8("after_rst", 8'd3, 8'd7, 16'd21, 0);

`ifdef SPM_SIGNED_EN
        op8("s_min_max", 8'h80, 8'h7F, 16'hC080, 0);
`endif

        // WIDTH=32 back-to-back with in_valid and out_ready tied high.
        @(negedge clk);
        a32 = 32'hFFFF_FFFF; b32 = 32'd2;
        in_valid32 = 1'b1; out_ready32 = 1'b1;
        acc_cnt = 0; out_cnt = 0;
        for (int cyc = 0; cyc < 250; cyc++) begin
            if (in_ready32 && acc_cnt < 3) begin
                acc_cyc[acc_cnt] = cyc;
                acc_cnt++;
            end
            if (out_valid32 && out_cnt < 2) begin
                chk("b2b_p32", p32, EXP_32);
                out_cnt++;
            end
            @(negedge clk);
        end
        in_valid32 = 1'b0;
        chk("b2b_accepts", 64'(acc_cnt), 64'd3);
        chk("b2b_outputs", 64'(out_cnt), 64'd2);
        if (acc_cnt == 3) begin
            chk("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd66);
            chk("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd66);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
